// File: rtl/gray_counter_param.sv
// Parametrised up/down counter with a registered binary count and its Gray code.
// Gray is derived from the next binary value, so both outputs update on the same edge.
module gray_counter_param #(
    parameter int unsigned WIDTH    = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q,   tc_d;

    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (up) begin
                if (bin_q == MAX) begin
                    tc_d  = 1'b1;
                    bin_d = SATURATE ? bin_q : '0;
                end else begin
                    bin_d = bin_q + 1'b1;
                end
            end else begin
                if (bin_q == '0) begin
                    tc_d  = 1'b1;
                    bin_d = SATURATE ? bin_q : MAX;
                end else begin
                    bin_d = bin_q - 1'b1;
                end
            end
        end
        // Encode the value about to be registered so gray never lags bin.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign tc   = tc_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: three instances (4-bit wrap, 4-bit saturate, 6-bit wrap)
// share one stimulus stream and are checked against an integer model of the counting rules.
module tb_gray_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, up, load;
    logic [5:0] lv;

    logic [3:0] bin_w, gray_w;
    logic       tc_w;
    logic [3:0] bin_s, gray_s;
    logic       tc_s;
    logic [5:0] bin_x, gray_x;
    logic       tc_x;

    gray_counter_param #(.WIDTH(4), .SATURATE(1'b0)) u_wrap4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
        .bin(bin_w), .gray(gray_w), .tc(tc_w)
    );
    gray_counter_param #(.WIDTH(4), .SATURATE(1'b1)) u_sat4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
        .bin(bin_s), .gray(gray_s), .tc(tc_s)
    );
    gray_counter_param #(.WIDTH(6), .SATURATE(1'b0)) u_wrap6 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
        .bin(bin_x), .gray(gray_x), .tc(tc_x)
    );

    int checks   = 0;
    int failures = 0;

    int unsigned W   [3] = '{4, 4, 6};
    bit          SAT [3] = '{1'b0, 1'b1, 1'b0};
    int unsigned mb  [3];
    bit          mt  [3];
    bit          moved [3];
    logic [31:0] pg  [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [32:0] b;
        b = '0;
        for (int i = 31; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b[31:0];
    endfunction

    function automatic logic [31:0] obs_bin(input int i);
        case (i)
            0:       return 32'(bin_w);
            1:       return 32'(bin_s);
            default: return 32'(bin_x);
        endcase
    endfunction

    function automatic logic [31:0] obs_gray(input int i);
        case (i)
            0:       return 32'(gray_w);
            1:       return 32'(gray_s);
            default: return 32'(gray_x);
        endcase
    endfunction

    function automatic logic [31:0] obs_tc(input int i);
        case (i)
            0:       return 32'(tc_w);
            1:       return 32'(tc_s);
            default: return 32'(tc_x);
        endcase
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int unsigned mx, old;
            mx  = (1 << W[i]) - 1;
            old = mb[i];
            if (rst) begin
                mb[i] = 0; mt[i] = 1'b0;
            end else if (load) begin
                mb[i] = 32'(lv) % (mx + 1); mt[i] = 1'b0;
            end else if (en) begin
                if (up) begin
                    if (mb[i] == mx) begin mt[i] = 1'b1; if (!SAT[i]) mb[i] = 0; end
                    else begin mb[i] = mb[i] + 1; mt[i] = 1'b0; end
                end else begin
                    if (mb[i] == 0) begin mt[i] = 1'b1; if (!SAT[i]) mb[i] = mx; end
                    else begin mb[i] = mb[i] - 1; mt[i] = 1'b0; end
                end
            end else begin
                mt[i] = 1'b0;
            end
            moved[i] = !rst && !load && en && (mb[i] != old);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] g;
            g = obs_gray(i);
            chk($sformatf("bin%0d", i),  obs_bin(i), mb[i]);
            chk($sformatf("gray%0d", i), g, mb[i] ^ (mb[i] >> 1));
            chk($sformatf("tc%0d", i),   obs_tc(i), 32'(mt[i]));
            chk($sformatf("decode%0d", i), gray2bin(g), mb[i]);
            if (moved[i]) chk($sformatf("onebit%0d", i), $countones(pg[i] ^ g), 1);
            pg[i] = g;
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic [5:0] v,
                       input logic e, input logic u);
        rst = r; load = l; lv = v; en = e; up = u;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        // Reset and count up
        cyc(1, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        repeat (3) cyc(0, 0, 0, 1, 1);
        chk("rs_bin3", 32'(bin_w), 3);
        chk("rs_gray3", 32'(gray_w), 4'b0010);

        // Wrap up from 14
        cyc(0, 1, 14, 0, 1);
        repeat (3) cyc(0, 0, 0, 1, 1);
        chk("wrap_up_bin", 32'(bin_w), 1);

        // Wrap down from 1, then saturate at 15
        cyc(0, 1, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 1, 0);
        chk("wrap_dn_bin", 32'(bin_w), 15);
        chk("wrap_dn_tc", 32'(tc_w), 1);
        cyc(0, 1, 15, 0, 1);
        repeat (3) cyc(0, 0, 0, 1, 1);
        chk("sat_bin", 32'(bin_s), 15);
        chk("sat_tc", 32'(tc_s), 1);

        // Priority rst > load > en
        cyc(1, 1, 9, 1, 1);
        chk("prio_rst", 32'(bin_w), 0);
        cyc(0, 1, 9, 1, 1);
        chk("prio_load_bin", 32'(bin_w), 9);
        chk("prio_load_gray", 32'(gray_w), 4'b1101);

        // Direction change then hold
        cyc(1, 0, 0, 0, 1);
        repeat (5) cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("hold_bin", 32'(bin_w), 4);
        chk("hold_gray", 32'(gray_w), 4'b0110);

        // Free run of the 6-bit instance through its wrap
        cyc(1, 0, 0, 0, 1);
        for (int k = 1; k <= 70; k++) begin
            cyc(0, 0, 0, 1, 1);
            if (k == 64) chk("x_tc64", 32'(tc_x), 1);
        end

        // Randomised mix of reset, load, enable and direction
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                6'($urandom_range(0, 63)), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised up/down counter that maintains a binary count and its registered Gray-code equivalent in lock-step.
- Successor to the fixed 4-bit combinational binary-to-Gray converter; adds width generalisation, direction control, synchronous load, wrap/saturate mode and a terminal-count flag.
- Used as a stimulus/pointer source (e.g. FIFO pointers, encoder emulation) where only one output bit may change per step.

Parameters:
- WIDTH, 4, counter and code width in bits (>=2).
- SATURATE, 0, 0 = wrap at the ends of the range; 1 = hold at the ends of the range.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  binary value to load.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin.
- tc  output  1  registered terminal-count pulse.

Behaviour:
- All outputs are registered on the rising edge of clk. There are no combinational paths from inputs to outputs.
- Reset (rst=1 at the clock edge): bin=0, gray=0, tc=0. rst overrides every other input, including a simultaneous load or en.
- Priority per cycle: rst > load > en > hold.
- Load (load=1, rst=0):
  - bin <= load_val.
  - gray <= load_val ^ (load_val >> 1).
  - tc <= 0.
  - en is ignored in that cycle.
- Count up (en=1, up=1):
  - bin < MAX (MAX = 2^WIDTH-1): bin <= bin+1, tc <= 0.
  - bin == MAX, SATURATE=0: bin <= 0, tc <= 1.
  - bin == MAX, SATURATE=1: bin holds, tc <= 1.
- Count down (en=1, up=0):
  - bin > 0: bin <= bin-1, tc <= 0.
  - bin == 0, SATURATE=0: bin <= MAX, tc <= 1.
  - bin == 0, SATURATE=1: bin holds, tc <= 1.
- Hold (en=0, load=0): bin and gray keep their values; tc <= 0.
- tc asserts once for each terminal step attempted. In saturate mode it stays high on every cycle in which a further step is attempted at the limit.
- gray is computed from the next binary value, not the current one. It is written in the same edge as bin, so gray == bin ^ (bin >> 1) holds in every cycle after reset, with zero lag.
- Step invariant: on every en-driven step that changes bin, exactly one bit of gray toggles. This includes the wrap steps MAX->0 and 0->MAX. Load is exempt.
- A direction change is legal on any cycle. The next step uses the new up value; no bubble cycle is inserted.
- Arithmetic is modulo 2^WIDTH with no carry-out port. Overflow is reported only through tc.
- A load value outside the range cannot occur, since load_val is exactly WIDTH bits.
- Reset mid-count returns both bin and gray to 0 on the next edge. Counting resumes in the following cycle if en=1.

Test Plan:
- Reset and step: WIDTH=4, rst=1 for 2 cycles then en=1, up=1. Required:
  - bin=0, gray=0, tc=0 during reset.
  - Then bin 1,2,3 with gray 0001, 0011, 0010.
  - gray==bin^(bin>>1) checked on every cycle.
- Wrap up: WIDTH=4, SATURATE=0, load 14, then en=1, up=1 for 3 cycles. Required:
  - bin 15, 0, 1.
  - gray 1000, 0000, 0001.
  - tc=1 only on the cycle bin becomes 0.
  - Exactly one gray bit changes per step.
- Wrap down and saturate: SATURATE=0, load 1, down 2 steps gives bin 0 then 15, with tc=1 on the 15. SATURATE=1, load 15, up 3 steps gives bin stays 15 and tc=1 on all 3 cycles.
- Priority: on one cycle assert rst=1, load=1, load_val=9, en=1, giving bin=0. The next cycle has load=1, load_val=9, en=1, up=1, giving bin=9, gray=1101, tc=0 (load wins over count).
- Direction change and hold:
  - Count up to 5, flip up=0 for one cycle: bin 5, 4.
  - Then en=0 for 3 cycles: bin stays 4, gray=0110, tc=0.
- Exhaustive (WIDTH=6): free-run up for 70 cycles from reset. Required:
  - Single-bit gray change on each step.
  - tc pulses at cycle 64.
  - Decoded gray equals bin on all cycles.
